shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle shift unit for the ALU shift path. Applies one fixed power-of-two shift stage
//  (16/8/4/2/1) per cycle, largest remaining first, until the requested amount is consumed.
//  Sits beside the ALU as an alternative to the single-cycle barrel shifter.
//  Start/ready handshake with the execute stage, like the mult/div unit.
// PARAMETERS
//  WIDTH    32  operand/result width; power of two
//  SHAMT_W  5   shift-amount width; must equal log2(WIDTH)
// PORTS
//  clock           in   1        rising-edge clock
//  reset           in   1        asynchronous, active-high reset
//  ctrl_start      in   1        1-cycle pulse; latch the operands below and begin
//  ctrl_op         in   2        00 SLL, 01 SRA, 10 SRL (macro-gated), 11 reserved
//  data_operandA   in   WIDTH    value to shift; sampled only on an accepted start
//  ctrl_shiftamt   in   SHAMT_W  shift distance; sampled only on an accepted start
//  data_result     out  WIDTH    shifted value; held stable from ready until the next accepted start
//  data_resultRDY  out  1        high for exactly 1 cycle when data_result is valid
//  busy            out  1        high in SHIFT state
// BEHAVIOUR
//  - Reset: state=IDLE; data_result=0, data_resultRDY=0, busy=0; internal regs cleared.
//    Reset mid-operation aborts the shift. No ready pulse follows.
//  - FSM (Moore outputs): IDLE, SHIFT, DONE.
//    - IDLE/DONE + ctrl_start: latch operand, amount and op.
//      - amount==0: go to DONE.
//      - otherwise: go to SHIFT.
//    - SHIFT: shift the working reg by 2^k, where k is the highest set bit of the remaining amount.
//      Clear bit k. If the remaining amount becomes 0, go to DONE.
//    - DONE: data_resultRDY=1. With no start, go to IDLE next cycle.
//  - Latency: start sampled at edge N; data_resultRDY high in cycle N+1+popcount(amount).
//    Amount 0 gives 1 cycle. Amount 31 gives 6 cycles (worst case).
//  - ctrl_start while busy: ignored. It does not queue and does not corrupt the operation in flight.
//  - A start in DONE is accepted. RDY still pulses that cycle; busy rises next cycle.
//  - Arithmetic:
//    - SLL: zero-fill from the LSB.
//    - SRA: replicate bit WIDTH-1 into the vacated MSBs.
//    - SRL: zero-fill from the MSB.
//    - Bits shifted out are discarded. No overflow or carry output.
//  - data_result updates only on entry to DONE. Its value outside the ready pulse is the last result.
// CONFIGURATION
//  SHIFT_SEQ_SRL_EN defined:
//    - op 10 performs logical right shift.
//    - op 11 behaves as SRA.
//  Not defined:
//    - ctrl_op[1] is ignored: 10 behaves as SLL, 11 as SRA.
//    - No SRL fill logic is synthesised.
// STRUCTURE
//  Package shift_seq_pkg:
//    - state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
//    - op codes: OP_SLL, OP_SRA, OP_SRL
//  Sub-module shift_stage_mux (combinational). Inputs: value, op, one-hot stage select.
//  Output: value shifted by the selected power of two. One instance feeds the working register.
//  Top level holds the FSM, working register, remaining-amount register, op register and
//  a priority encoder for the highest set bit.
// TESTING
//  1. start, op=SRA, A=32'h8000_0000, amt=31
//     -> RDY at N+6 (exactly 1 cycle); result=32'hFFFF_FFFF
//  2. start, op=SLL, A=32'h0000_0001, amt=5
//     -> stages 4,1; RDY at N+3; result=32'h0000_0020
//  3. start, amt=0, A=32'h1234_5678
//     -> RDY at N+1; result=32'h1234_5678; busy never high
//  4. second start 1 cycle after the first (amt=31) with different A
//     -> ignored; result matches the first operand only
//  5. assert reset during SHIFT (case 1, cycle N+3)
//     -> outputs 0 immediately; no RDY; a fresh start afterwards completes normally
//  6. op=10, A=32'h8000_0000, amt=4
//     -> macro defined: result=32'h0800_0000
//     -> macro undefined: result=32'h0000_0000 (SLL)

Source files
------------

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared FSM states, op codes and op normalisation for shift_sequencer.
// SHIFT_SEQ_SRL_EN selects whether op 10 is a logical right shift or folds onto SLL.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;

    // Map the raw op field onto the ops the build actually implements.
    function automatic logic [1:0] normOp(input logic [1:0] op);
`ifdef SHIFT_SEQ_SRL_EN
        return op == 2'b11 ? OP_SRA : op;
`else
        return op & 2'b01;
`endif
    endfunction

endpackage

// File: rtl/shift_stage_mux.sv
// shift_stage_mux: shifts a value by the single power of two picked by a one-hot stage select.
// The SRL fill path exists only when SHIFT_SEQ_SRL_EN is defined.
module shift_stage_mux
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] stageSel,
    output logic [WIDTH-1:0]   result
);

    logic [WIDTH-1:0] stageOut [SHAMT_W];

    for (genvar k = 0; k < SHAMT_W; k++) begin : gStage
        localparam int S = 1 << k;
`ifdef SHIFT_SEQ_SRL_EN
        assign stageOut[k] = op == OP_SLL ? value << S :
                             op == OP_SRL ? value >> S : $unsigned($signed(value) >>> S);
`else
        assign stageOut[k] = op == OP_SLL ? value << S : $unsigned($signed(value) >>> S);
`endif
    end

    always_comb begin
        result = '0;
        for (int i = 0; i < SHAMT_W; i++) result |= stageOut[i] & {WIDTH{stageSel[i]}};
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter consuming the largest remaining power-of-two stage each cycle.
// Define SHIFT_SEQ_SRL_EN to enable logical right shift on op 10.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [1:0]         ctrl_op,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    state_t             state, nextState;
    logic [WIDTH-1:0]   workReg, stageOut;
    logic [SHAMT_W-1:0] remAmt, remNext, stageSel;
    logic [1:0]         opReg;
    logic               accept;

    // Priority encoder: the last set bit seen wins, so the highest remaining stage is selected.
    always_comb begin
        stageSel = '0;
        for (int i = 0; i < SHAMT_W; i++)
            if (remAmt[i]) stageSel = SHAMT_W'(1) << i;
    end

    assign remNext = remAmt & ~stageSel;
    assign accept  = ctrl_start && state != SHIFT;

    shift_stage_mux #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) stageMux (
        .value(workReg),
        .op(opReg),
        .stageSel(stageSel),
        .result(stageOut)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= nextState;

    always_comb begin
        nextState = state;
        data_resultRDY = state == DONE;
        busy = state == SHIFT;
        case (state)
            IDLE, DONE: nextState = accept ? (ctrl_shiftamt == '0 ? DONE : SHIFT) : IDLE;
            SHIFT: nextState = remNext == '0 ? DONE : SHIFT;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            workReg <= '0;
            remAmt <= '0;
            opReg <= OP_SLL;
            data_result <= '0;
        end else if (accept) begin
            workReg <= data_operandA;
            remAmt <= ctrl_shiftamt;
            opReg <= normOp(ctrl_op);
            if (ctrl_shiftamt == '0) data_result <= data_operandA;
        end else if (state == SHIFT) begin
            workReg <= stageOut;
            remAmt <= remNext;
            if (remNext == '0) data_result <= stageOut;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench; driver queues expected results, monitor checks on every ready pulse.
// Honours SHIFT_SEQ_SRL_EN in its reference model.
module tb_shift_sequencer;

    logic        clock = 0;
    logic        reset = 1;
    logic        ctrl_start = 0;
    logic [1:0]  ctrl_op = 0;
    logic [31:0] data_operandA = 0;
    logic [4:0]  ctrl_shiftamt = 0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] lastResult = 0;

    shift_sequencer dut (
        .clock(clock),
        .reset(reset),
        .ctrl_start(ctrl_start),
        .ctrl_op(ctrl_op),
        .data_operandA(data_operandA),
        .ctrl_shiftamt(ctrl_shiftamt),
        .data_result(data_result),
        .data_resultRDY(data_resultRDY),
        .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt);
        logic [31:0] sra;
        sra = $unsigned($signed(a) >>> amt);
`ifdef SHIFT_SEQ_SRL_EN
        if (op == 2'b10) return a >> amt;
        return op == 2'b00 ? a << amt : sra;
`else
        return op[0] ? sra : a << amt;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset) lastResult = '0;
        else if (data_resultRDY) begin
            if (sb.size() == 0) check("spurious_rdy", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check("result", data_result, e.res);
                check("latency", cyc, e.cyc);
                lastResult = e.res;
            end
        end else check("hold", data_result, lastResult);
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt);
        ctrl_start = 1;
        ctrl_op = op;
        data_operandA = a;
        ctrl_shiftamt = amt;
        @(posedge clock);
        #1;
        ctrl_start = 0;
        sb.push_back('{model(op, a, amt), cyc + $countones(amt)});
        check("busy_after_start", busy, amt != 0);
    endtask

    task automatic junkStart();
        ctrl_start = 1;
        ctrl_op = 2'($urandom);
        data_operandA = $urandom;
        ctrl_shiftamt = 5'($urandom);
        @(posedge clock);
        #1;
        ctrl_start = 0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) return;
        end
        check("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #1;
        check("reset_result", data_result, 0);
        check("reset_rdy", data_resultRDY, 0);
        check("reset_busy", busy, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        @(posedge clock);
        #1;
        issue(2'b01, 32'h8000_0000, 31);
        waitDone();
        issue(2'b00, 32'h0000_0001, 5);
        waitDone();
        issue(2'b00, 32'h1234_5678, 0);
        waitDone();
        issue(2'b00, 32'hDEAD_BEEF, 31);
        ctrl_start = 1;
        data_operandA = 32'h0000_FFFF;
        ctrl_op = 2'b01;
        @(posedge clock);
        #1;
        ctrl_start = 0;
        waitDone();
        issue(2'b10, 32'h8000_0000, 4);
        waitDone();
        issue(2'b01, 32'h8000_0000, 31);
        repeat (2) @(posedge clock);
        #1;
        reset = 1;
        sb.delete();
        #1;
        check("abort_result", data_result, 0);
        check("abort_rdy", data_resultRDY, 0);
        check("abort_busy", busy, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        repeat (8) @(posedge clock);
        #1;
        issue(2'b01, 32'hF0F0_0000, 13);
        waitDone();
        for (int n = 0; n < 200; n++) begin
            logic [4:0] amt;
            amt = 5'($urandom);
            if ($urandom_range(0, 3) == 0) amt = 0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
            issue(2'($urandom), $urandom, amt);
            if (amt != 0 && $urandom_range(0, 2) == 0) junkStart();
            waitDone();
        end
        repeat (4) @(posedge clock);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
